// File: rtl/fifo_input_deserializer_pkg.sv
// Shared definitions for the FIFO-to-parallel deserializer: FSM states and
// counter sizing.
package fifo_input_deserializer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } deser_state_e;

   // Counter must represent LAYER_HEIGHT itself, not just LAYER_HEIGHT-1.
   function automatic int unsigned count_width(input int unsigned layer_height);
      return $clog2(layer_height + 1);
   endfunction

endpackage

// File: rtl/fifo_input_deserializer_if.sv
// FIFO read side plus valid/yumi consumer side of the deserializer.
interface fifo_input_deserializer_if
   import fifo_input_deserializer_pkg::*;
#(
   parameter int unsigned LAYER_HEIGHT = 256,
   parameter int unsigned WORD_SIZE    = 16
);
   localparam int unsigned CW = count_width(LAYER_HEIGHT);

   logic [WORD_SIZE-1:0]                   data_i;
   logic                                   empty_i;
   logic                                   ren_o;
   logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o;
   logic                                   valid_o;
   logic                                   yumi_i;
   logic [CW-1:0]                          count_o;

   modport master (
      input  data_i, empty_i, yumi_i,
      output ren_o, data_o, valid_o, count_o
   );

   modport slave (
      output data_i, empty_i, yumi_i,
      input  ren_o, data_o, valid_o, count_o
   );
endinterface

// File: rtl/fifo_input_deserializer.sv
// Pops LAYER_HEIGHT words from a first-word-fall-through FIFO and presents
// them as one parallel vector under a valid/yumi handshake.
module fifo_input_deserializer
   import fifo_input_deserializer_pkg::*;
#(
   parameter int unsigned LAYER_HEIGHT = 256,
   parameter int unsigned WORD_SIZE    = 16
) (
   input logic                     clk_i,
   input logic                     reset_n_i,
   fifo_input_deserializer_if.master bus
);
   localparam int unsigned CW = count_width(LAYER_HEIGHT);

   deser_state_e                           state_q, state_d;
   logic [CW-1:0]                          count_q;
   logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_q;
   logic                                   ren;
   logic                                   last_word;

   assign last_word = (count_q == CW'(LAYER_HEIGHT - 1));

   // Pop is gated by reset so the FIFO is never drained while held in reset.
   always_comb begin
      state_d = state_q;
      ren     = 1'b0;
      unique case (state_q)
         FILL: begin
            ren = reset_n_i && !bus.empty_i;
            if (ren && last_word)
               state_d = FULL;
         end
         FULL: begin
            if (bus.yumi_i)
               state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= FILL;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (ren) begin
            count_q <= count_q + CW'(1);
            for (int unsigned i = 0; i < LAYER_HEIGHT; i++) begin
               if (count_q == CW'(i))
                  data_q[i] <= bus.data_i;
            end
         end else if (state_q == FULL && bus.yumi_i) begin
            count_q <= '0;
         end
      end
   end

   assign bus.ren_o   = ren;
   assign bus.data_o  = data_q;
   assign bus.valid_o = (state_q == FULL);
   assign bus.count_o = count_q;

endmodule

// File: tb/tb_fifo_input_deserializer.sv
// Directed bench for fifo_input_deserializer with LAYER_HEIGHT=4, WORD_SIZE=16;
// a queue stands in for the first-word-fall-through FIFO.
module tb_fifo_input_deserializer;
   localparam int unsigned LH = 4;
   localparam int unsigned WS = 16;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   logic [WS-1:0] fifo_q[$];
   logic [63:0]   held;

   fifo_input_deserializer_if #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) bus ();

   fifo_input_deserializer #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      bus.empty_i = (fifo_q.size() == 0);
      bus.data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // One clock: pop the head if ren was high at the edge, then refresh inputs.
   task automatic cycle();
      logic popped;
      popped = bus.ren_o;
      @(posedge clk);
      if (popped && fifo_q.size() != 0)
         void'(fifo_q.pop_front());
      #1;
      drive_fifo();
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      bus.yumi_i = 1'b0;
      fifo_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
      drive_fifo();

      // Reset with a non-empty FIFO
      repeat (3) @(posedge clk);
      #2;
      check("rst_ren",   64'(bus.ren_o),   64'd0);
      check("rst_valid", 64'(bus.valid_o), 64'd0);
      check("rst_count", 64'(bus.count_o), 64'd0);
      check("rst_data",  bus.data_o,       64'd0);
      reset_n = 1'b1;
      #1;
      check("rel_ren", 64'(bus.ren_o), 64'd1);

      // Back-to-back fill of 1..4
      cycle();
      check("fill_cnt1", 64'(bus.count_o), 64'd1);
      check("fill_val1", 64'(bus.valid_o), 64'd0);
      cycle();
      cycle();
      check("fill_cnt3", 64'(bus.count_o), 64'd3);
      check("fill_ren3", 64'(bus.ren_o),   64'd1);
      check("fill_val3", 64'(bus.valid_o), 64'd0);
      cycle();
      check("full_valid", 64'(bus.valid_o), 64'd1);
      check("full_count", 64'(bus.count_o), 64'd4);
      check("full_data",  bus.data_o, 64'h0004_0003_0002_0001);
      check("full_empty", 64'(bus.empty_i), 64'd0);
      check("full_ren",   64'(bus.ren_o),   64'd0);

      // Hold without yumi, then a single-cycle yumi
      held = 64'h0004_0003_0002_0001;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("hold_data",  bus.data_o, held);
         check("hold_valid", 64'(bus.valid_o), 64'd1);
      end
      bus.yumi_i = 1'b1;
      #1;
      check("yumi_ren", 64'(bus.ren_o), 64'd0);
      cycle();
      bus.yumi_i = 1'b0;
      #1;
      check("ack_valid", 64'(bus.valid_o), 64'd0);
      check("ack_count", 64'(bus.count_o), 64'd0);
      check("ack_data",  bus.data_o, held);
      check("ack_ren",   64'(bus.ren_o), 64'd1);

      // Empty gap of 3 cycles between words 2 and 3; stray yumi is ignored
      fifo_q.push_back(16'h0006);
      drive_fifo();
      #1;
      cycle();
      check("gap_cnt1", 64'(bus.count_o), 64'd1);
      check("gap_d0",   64'(bus.data_o[0]), 64'h0005);
      cycle();
      check("gap_cnt2", 64'(bus.count_o), 64'd2);
      bus.yumi_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("gap_ren", 64'(bus.ren_o), 64'd0);
         cycle();
         check("gap_hold_cnt", 64'(bus.count_o), 64'd2);
         check("gap_hold_val", 64'(bus.valid_o), 64'd0);
      end
      bus.yumi_i = 1'b0;
      check("gap_data", bus.data_o, 64'h0004_0003_0006_0005);
      fifo_q.push_back(16'h0007);
      fifo_q.push_back(16'h0008);
      drive_fifo();
      #1;
      cycle();
      check("gap_cnt3",  64'(bus.count_o), 64'd3);
      check("gap_val3",  64'(bus.valid_o), 64'd0);
      cycle();
      check("gap_valid", 64'(bus.valid_o), 64'd1);
      check("gap_vec",   bus.data_o, 64'h0008_0007_0006_0005);

      // Empty FIFO while FULL has no effect
      cycle();
      check("fe_valid", 64'(bus.valid_o), 64'd1);
      check("fe_count", 64'(bus.count_o), 64'd4);
      bus.yumi_i = 1'b1;
      cycle();
      bus.yumi_i = 1'b0;
      #1;
      check("fe_ack", 64'(bus.valid_o), 64'd0);

      // Reset mid-fill discards the partial vector
      fifo_q.push_back(16'h000A);
      fifo_q.push_back(16'h000B);
      drive_fifo();
      #1;
      cycle();
      cycle();
      check("mid_cnt2", 64'(bus.count_o), 64'd2);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cnt",  64'(bus.count_o), 64'd0);
      check("mid_rst_data", bus.data_o, 64'd0);
      check("mid_rst_ren",  64'(bus.ren_o), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      fifo_q = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
      drive_fifo();
      #1;
      repeat (4) cycle();
      check("mid_valid", 64'(bus.valid_o), 64'd1);
      check("mid_vec",   bus.data_o, 64'h000D_000C_000B_000A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_input_deserializer.md
Name: fifo_input_deserializer

Overview:
- Receiving end of the serial word stream that fc_output_layer writes into double_fifo.
- Pops words from a first-word-fall-through FIFO and assembles LAYER_HEIGHT words into one parallel vector.
- Presents the vector with a valid/yumi handshake.
- Sits between an output-side FIFO and any consumer needing a full parallel layer: the testbench scoreboard, or a downstream parallel fc layer.

Parameters:
- LAYER_HEIGHT, 256, number of words per assembled vector (>=1).
- WORD_SIZE, 16, bits per word.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_n_i  input  1  asynchronous reset, active-low.
- data_i  input  WORD_SIZE  FIFO head word; valid whenever empty_i=0 (first-word-fall-through).
- empty_i  input  1  FIFO empty flag.
- ren_o  output  1  FIFO pop; the head word is consumed on a clock edge where ren_o=1.
- data_o  output  [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  assembled vector; element 0 is the first word popped.
- valid_o  output  1  data_o holds a complete vector.
- yumi_i  input  1  consumer accepts data_o. Legal only while valid_o=1.
- count_o  output  $clog2(LAYER_HEIGHT+1)  words captured into the current vector.

Behaviour:
- Interface (fixed): one clock, clk_i; reset_n_i is asynchronous, active-low.
- Reset (reset_n_i=0, asynchronous):
  - state=FILL, count_o=0, valid_o=0, data_o all zeros.
  - ren_o=0 for the whole time reset is asserted.
- Reset mid-fill discards the partial vector. Words already popped are lost, not replayed.

States:
- FILL:
  - ren_o = !empty_i (combinational; never asserted while empty_i=1).
  - On an edge with ren_o=1: data_o[count] <= data_i and count <= count+1.
  - Other elements of data_o hold their values.
  - If the captured word is index LAYER_HEIGHT-1: go to FULL and set valid_o=1 on that same edge.
  - Latency: valid_o rises on the edge that captures the last word. With a never-empty FIFO, that is LAYER_HEIGHT cycles after leaving reset/FULL.
- FULL:
  - ren_o=0, valid_o=1.
  - data_o and count_o (=LAYER_HEIGHT) are stable and must not change until accepted.
  - On an edge with yumi_i=1: valid_o <= 0, count <= 0, state <= FILL.
  - data_o keeps its old contents; it is not cleared.
  - No word is popped in the yumi cycle. The first pop of the next vector happens the following cycle at the earliest, so there is a 1-cycle bubble per vector.

Boundary conditions:
- yumi_i while valid_o=0: ignored, no state change.
- empty_i toggling mid-fill: count and data_o hold through empty cycles; no timeout.
- empty_i=1 while in FULL: no effect.
- LAYER_HEIGHT=1: every pop goes directly to FULL.
- Counter width must hold LAYER_HEIGHT exactly; no wrap past LAYER_HEIGHT-1 inside FILL.
- Data is passed bit-exact; no sign extension or arithmetic.

Decomposition:
- Shared package (existing network package):
  - typedef enum logic {FILL, FULL} deser_state_e.
  - function for counter width, clog2(LAYER_HEIGHT+1).
- Single module; no sub-module is warranted.
- Element write-enable decode and the counter stay inline.

Test Plan (LAYER_HEIGHT=4, WORD_SIZE=16 unless noted):
1. Reset with a non-empty FIFO -> ren_o=0, valid_o=0, count_o=0, data_o=0 during reset; popping starts the first cycle after release.
2. Feed 0x0001,0x0002,0x0003,0x0004 back-to-back, yumi_i=0 -> ren_o high 4 cycles; valid_o=1 on the 4th capture edge; data_o={0x0004,0x0003,0x0002,0x0001}; ren_o stays 0 while the FIFO holds 0x0005.
3. Continue scenario 2: hold yumi_i=0 for 10 cycles, then pulse 1 cycle -> data_o unchanged throughout; valid_o drops next edge; 0x0005 popped the cycle after yumi.
4. empty_i=1 for 3 cycles between words 2 and 3 -> count_o holds at 2, ren_o=0, the final vector is still correct, valid_o is delayed exactly 3 cycles.
5. Assert reset_n_i low after 2 of 4 words, then feed 0xA,0xB,0xC,0xD -> data_o={0xD,0xC,0xB,0xA}; no stale words appear.
6. LAYER_HEIGHT=256, 100 random vectors via fc_output_layer -> double_fifo -> this block; yumi_i asserted with a random delay -> every output vector equals the corresponding input vector bit-exact.
